// File: rtl/seg7_disp_sched.sv
// Display scheduler: round-robin sharing of one 8-digit seven-segment driver between
// N_REQ requesters, with minimum dwell, blank gap between owners and a pin override.
module seg7_disp_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DWELL = 50_000_000,
    parameter int unsigned GAP   = 5_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_mode,
    input  logic [64*N_REQ-1:0]      req_data,
    input  logic                     pin_en,
    input  logic [$clog2(N_REQ)-1:0] pin_sel,
    output logic [N_REQ-1:0]         grant,
    output logic                     disp_mode,
    output logic [63:0]              disp_data,
    output logic                     switch_pulse
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned NPad = 1 << IdxW;
    localparam int unsigned DwW  = $clog2(DWELL);
    localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [DwW-1:0]  DwellMax  = DwW'(DWELL - 1);
    localparam logic [GapW-1:0] GapMax    = GapW'(GAP - 1);
    localparam logic [63:0]     BlankData = '1;

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   gidx_q, gidx_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [DwW-1:0]    dwell_q, dwell_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              disp_mode_q, disp_mode_d;
    logic [63:0]       disp_data_q, disp_data_d;
    logic              switch_pulse_q, switch_pulse_d;

    logic [63:0]       slot [N_REQ];
    logic [NPad-1:0]   req_pad;
    logic              pin_act;
    logic              any_req;
    logic              others_pending;
    logic              rr_found;
    logic [IdxW-1:0]   rr_idx;
    logic [IdxW-1:0]   sel_idx;
    logic              start;
    int unsigned       cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign slot[i] = req_data[64*i +: 64];
    end

    // Padding keeps req[pin_sel] in range when N_REQ is not a power of two.
    always_comb begin
        req_pad        = NPad'(req);
        pin_act        = pin_en && req_pad[pin_sel];
        any_req        = |req;
        others_pending = |(req & ~grant_q);
        rr_found       = 1'b0;
        rr_idx         = ptr_q;
        cand           = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr_q) + k) % N_REQ;
            if (!rr_found && req[cand[IdxW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IdxW-1:0];
            end
        end
        sel_idx = pin_act ? pin_sel : rr_idx;
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        gidx_d         = gidx_q;
        grant_d        = grant_q;
        dwell_d        = dwell_q;
        gap_d          = gap_q;
        disp_mode_d    = 1'b1;
        disp_data_d    = BlankData;
        switch_pulse_d = 1'b0;
        start          = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                start   = any_req;
            end
            StShow: begin
                dwell_d = (dwell_q == DwellMax) ? dwell_q : dwell_q + 1'b1;
                // A drop wins over dwell expiry; a pin on the owner suppresses rotation.
                if (!req[gidx_q] || (pin_act && pin_sel != gidx_q) ||
                    (!pin_act && dwell_q == DwellMax && others_pending)) begin
                    state_d = StBlank;
                    grant_d = '0;
                    gap_d   = '0;
                end else begin
                    disp_data_d = slot[gidx_q];
                    disp_mode_d = req_mode[gidx_q];
                end
            end
            StBlank: begin
                grant_d = '0;
                if (gap_q == GapMax) begin
                    gap_d = '0;
                    if (any_req) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        if (start) begin
            state_d        = StShow;
            gidx_d         = sel_idx;
            ptr_d          = sel_idx;
            grant_d        = N_REQ'(1) << sel_idx;
            dwell_d        = '0;
            disp_data_d    = slot[sel_idx];
            disp_mode_d    = req_mode[sel_idx];
            switch_pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            ptr_q          <= IdxW'(N_REQ - 1);
            gidx_q         <= '0;
            grant_q        <= '0;
            dwell_q        <= '0;
            gap_q          <= '0;
            disp_mode_q    <= 1'b1;
            disp_data_q    <= BlankData;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            gidx_q         <= gidx_d;
            grant_q        <= grant_d;
            dwell_q        <= dwell_d;
            gap_q          <= gap_d;
            disp_mode_q    <= disp_mode_d;
            disp_data_q    <= disp_data_d;
            switch_pulse_q <= switch_pulse_d;
        end
    end

    assign grant        = grant_q;
    assign disp_mode    = disp_mode_q;
    assign disp_data    = disp_data_q;
    assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Directed self-checking bench for seg7_disp_sched with N_REQ=4, DWELL=8, GAP=2.
module tb_seg7_disp_sched;

    localparam logic [63:0] Blank = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   req_mode;
    logic [255:0] req_data;
    logic         pin_en;
    logic [1:0]   pin_sel;
    logic [3:0]   grant;
    logic         disp_mode;
    logic [63:0]  disp_data;
    logic         switch_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] slot_val [4];

    seg7_disp_sched #(
        .N_REQ (4),
        .DWELL (8),
        .GAP   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_mode     (req_mode),
        .req_data     (req_data),
        .pin_en       (pin_en),
        .pin_sel      (pin_sel),
        .grant        (grant),
        .disp_mode    (disp_mode),
        .disp_data    (disp_data),
        .switch_pulse (switch_pulse)
    );

    always #5 clk = ~clk;

    task automatic load_data();
        for (int i = 0; i < 4; i++) req_data[64*i +: 64] = slot_val[i];
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req     = '0;
        pin_en  = 1'b0;
        pin_sel = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        pin_en = 1'b0;
        pin_sel = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
        n_checks++; if (disp_mode !== 1'b1) begin n_fail++; $display("FAIL reset_mode got %b want 1", disp_mode); end
        n_checks++; if (disp_data !== Blank) begin n_fail++; $display("FAIL reset_data got %h want %h", disp_data, Blank); end
        n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", switch_pulse); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b want 0001", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL reset_first_pulse got %b want 1", switch_pulse); end
        n_checks++; if (disp_data !== slot_val[0]) begin n_fail++; $display("FAIL reset_first_data got %h want %h", disp_data, slot_val[0]); end
        n_checks++; if (disp_mode !== 1'b0) begin n_fail++; $display("FAIL reset_first_mode got %b want 0", disp_mode); end
        @(negedge clk);
        n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse_once got %b want 0", switch_pulse); end
    endtask

    // Upward search from pointer+1: owners 0, 1, 3 (2 never requests), then 0 again.
    task automatic test_round_robin();
        logic [3:0]  owners [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        int unsigned oidx [4]   = '{0, 1, 3, 0};
        logic [3:0]  eg;
        logic [63:0] ed;
        logic        em;
        logic        ep;
        do_reset();
        req = 4'b1011;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c % 10 < 8) begin
                eg = owners[c/10];
                ed = slot_val[oidx[c/10]];
                em = req_mode[oidx[c/10]];
            end else begin
                eg = 4'b0000;
                ed = Blank;
                em = 1'b1;
            end
            ep = (c % 10 == 0);
            n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL rr_grant c=%0d got %b want %b", c, grant, eg); end
            n_checks++; if (switch_pulse !== ep) begin n_fail++; $display("FAIL rr_pulse c=%0d got %b want %b", c, switch_pulse, ep); end
            n_checks++; if (disp_data !== ed) begin n_fail++; $display("FAIL rr_data c=%0d got %h want %h", c, disp_data, ed); end
            n_checks++; if (disp_mode !== em) begin n_fail++; $display("FAIL rr_mode c=%0d got %b want %b", c, disp_mode, em); end
        end
    endtask

    task automatic test_sole_requester();
        logic [63:0] old_val;
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL sole_grant got %b want 0100", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL sole_pulse got %b want 1", switch_pulse); end
        n_checks++; if (disp_data !== slot_val[2]) begin n_fail++; $display("FAIL sole_data got %h want %h", disp_data, slot_val[2]); end
        for (int c = 1; c < 21; c++) begin
            @(negedge clk);
            n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL sole_hold c=%0d got %b want 0100", c, grant); end
            n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL sole_hold_pulse c=%0d got %b want 0", c, switch_pulse); end
        end
        old_val     = slot_val[2];
        slot_val[2] = 64'h5555_6666_7777_8888;
        load_data();
        #1;
        n_checks++; if (disp_data !== old_val) begin n_fail++; $display("FAIL sole_data_registered got %h want %h", disp_data, old_val); end
        @(negedge clk);
        n_checks++; if (disp_data !== 64'h5555_6666_7777_8888) begin n_fail++; $display("FAIL sole_data_track got %h want 5555666677778888", disp_data); end
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL sole_track_grant got %b want 0100", grant); end
        slot_val[2] = old_val;
        load_data();
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 4'b0011;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL drop_start got %b want 0001", grant); end
        repeat (3) @(negedge clk);
        req = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL drop_blank c=%0d got %b want 0000", c, grant); end
            n_checks++; if (disp_data !== Blank) begin n_fail++; $display("FAIL drop_blank_data c=%0d got %h want %h", c, disp_data, Blank); end
        end
        @(negedge clk);
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL drop_next got %b want 0010", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL drop_next_pulse got %b want 1", switch_pulse); end
        n_checks++; if (disp_data !== slot_val[1]) begin n_fail++; $display("FAIL drop_next_data got %h want %h", disp_data, slot_val[1]); end

        do_reset();
        req = 4'b0001;
        repeat (4) @(negedge clk);
        req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL drop_idle c=%0d got %b want 0000", c, grant); end
            n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_idle_pulse c=%0d got %b want 0", c, switch_pulse); end
            n_checks++; if (disp_mode !== 1'b1) begin n_fail++; $display("FAIL drop_idle_mode c=%0d got %b want 1", c, disp_mode); end
        end
        req = 4'b0100;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL drop_idle_regrant got %b want 0100", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL drop_idle_regrant_pulse got %b want 1", switch_pulse); end
    endtask

    task automatic test_pin();
        do_reset();
        req = 4'b1011;
        repeat (11) @(negedge clk);
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL pin_pre got %b want 0010", grant); end
        repeat (2) @(negedge clk);
        pin_en  = 1'b1;
        pin_sel = 2'd3;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL pin_blank c=%0d got %b want 0000", c, grant); end
            n_checks++; if (disp_data !== Blank) begin n_fail++; $display("FAIL pin_blank_data c=%0d got %h want %h", c, disp_data, Blank); end
        end
        @(negedge clk);
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL pin_grant got %b want 1000", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL pin_pulse got %b want 1", switch_pulse); end
        n_checks++; if (disp_data !== slot_val[3]) begin n_fail++; $display("FAIL pin_data got %h want %h", disp_data, slot_val[3]); end
        n_checks++; if (disp_mode !== 1'b1) begin n_fail++; $display("FAIL pin_mode got %b want 1", disp_mode); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL pin_hold c=%0d got %b want 1000", c, grant); end
        end
        pin_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL unpin_blank c=%0d got %b want 0000", c, grant); end
        end
        @(negedge clk);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL unpin_resume got %b want 0001", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL unpin_pulse got %b want 1", switch_pulse); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b1011;
        repeat (9) @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mrst_in_blank got %b want 0000", grant); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mrst_blank_grant got %b want 0000", grant); end
        n_checks++; if (disp_data !== Blank) begin n_fail++; $display("FAIL mrst_blank_data got %h want %h", disp_data, Blank); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mrst_blank_restart got %b want 0001", grant); end
        n_checks++; if (switch_pulse !== 1'b1) begin n_fail++; $display("FAIL mrst_blank_pulse got %b want 1", switch_pulse); end
        repeat (10) @(negedge clk);
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL mrst_show_pre got %b want 0010", grant); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mrst_show_grant got %b want 0000", grant); end
        n_checks++; if (disp_data !== Blank) begin n_fail++; $display("FAIL mrst_show_data got %h want %h", disp_data, Blank); end
        n_checks++; if (disp_mode !== 1'b1) begin n_fail++; $display("FAIL mrst_show_mode got %b want 1", disp_mode); end
        n_checks++; if (switch_pulse !== 1'b0) begin n_fail++; $display("FAIL mrst_show_pulse got %b want 0", switch_pulse); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mrst_show_restart got %b want 0001", grant); end
    endtask

    initial begin
        rst         = 1'b1;
        req         = '0;
        pin_en      = 1'b0;
        pin_sel     = '0;
        req_mode    = 4'b1010;
        slot_val[0] = 64'h0000_0000_1234_5678;
        slot_val[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        slot_val[2] = 64'h0123_4567_89AB_CDEF;
        slot_val[3] = 64'hFEDC_BA98_7654_3210;
        load_data();
        test_reset();
        test_round_robin();
        test_sole_requester();
        test_early_drop();
        test_pin();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
